kernel_nios2_gen2_cpu_debug_mem_bridge: RTL and testbench

//  Consumes the ocimem command strobes and 38-bit jdo word from the debug-slave wrapper.

---
 rtl/kernel_nios2_gen2_cpu_debug_mem_bridge_pkg.sv | 16 +
 rtl/kernel_nios2_gen2_cpu_debug_mem_bridge_if.sv | 11 +
 rtl/kernel_nios2_gen2_cpu_debug_mem_bridge_cmdq.sv | 26 ++
 rtl/kernel_nios2_gen2_cpu_debug_mem_bridge.sv | 101 ++++++++++
 tb/tb_kernel_nios2_gen2_cpu_debug_mem_bridge.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_nios2_gen2_cpu_debug_mem_bridge_pkg.sv
// kernel_nios2_gen2_cpu_debug_mem_bridge_pkg: jdo field layout, opcode/state types and defaults for the debug memory bridge
package kernel_nios2_gen2_cpu_debug_mem_bridge_pkg;
    localparam int JDO_W        = 38;
    localparam int JDO_CLR      = 33;
    localparam int JDO_LOAD     = 34;
    localparam int JDO_READ     = 35;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_LSB = 3;
    localparam int DEF_TIMEOUT  = 15;
    typedef enum logic [1:0] {OP_A, OP_B, OP_C} op_t;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef struct packed {
        op_t              op;
        logic [JDO_W-1:0] jdo;
    } cmd_t;
endpackage

// File: rtl/kernel_nios2_gen2_cpu_debug_mem_bridge_if.sv
// kernel_nios2_gen2_cpu_debug_mem_bridge_if: 32-bit debug memory request/ack port
interface kernel_nios2_gen2_cpu_debug_mem_bridge_if #(parameter int ADDR_W = 8);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/kernel_nios2_gen2_cpu_debug_mem_bridge_cmdq.sv
// kernel_nios2_gen2_cpu_debug_mem_bridge_cmdq: one-entry pending command slot; a push while popping reuses the slot
module kernel_nios2_gen2_cpu_debug_mem_bridge_cmdq
    import kernel_nios2_gen2_cpu_debug_mem_bridge_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_cmd,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic overflow
);
    logic take;
    assign take     = push && (!full || pop);
    assign overflow = push && full && !pop;
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            head <= '0;
        end else begin
            full <= take || (full && !pop);
            if (take) head <= push_cmd;
        end
    end
endmodule

// File: rtl/kernel_nios2_gen2_cpu_debug_mem_bridge.sv
// kernel_nios2_gen2_cpu_debug_mem_bridge: executes JTAG ocimem commands A/B/C on the debug memory port
module kernel_nios2_gen2_cpu_debug_mem_bridge
    import kernel_nios2_gen2_cpu_debug_mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [JDO_W-1:0] jdo,
    input  logic             take_action_ocimem_a,
    input  logic             take_action_ocimem_b,
    input  logic             take_no_action_ocimem_a,
    kernel_nios2_gen2_cpu_debug_mem_bridge_if.master mem,
    output logic [31:0]      MonDReg,
    output logic             monitor_ready,
    output logic             monitor_error
);
    state_t            state, state_n;
    cmd_t              cur, head, first, second, issue_cmd, push_cmd;
    logic [ADDR_W-1:0] addr, base_addr;
    logic [7:0]        tcnt;
    logic a, b, c, first_v, second_v, third_v;
    logic can_issue, direct, from_slot, issue_v, issue_mem;
    logic push, pop, full, overflow, drop, ack_now, tout;
    logic unused_bits;

    assign a = take_action_ocimem_a;
    assign b = take_action_ocimem_b;
    assign c = take_no_action_ocimem_a;
    assign unused_bits = ^{cur.jdo[JDO_W-1:JDO_READ], cur.jdo[JDO_DATA_LSB-1:0], cur.jdo[JDO_ADDR_LSB +: ADDR_W]};

    // Priority A > B > C: the top strobe may execute, the next may queue, the rest are dropped.
    always_comb begin
        first_v   = a || b || c;
        second_v  = a ? (b || c) : (b && c);
        third_v   = a && b && c;
        first     = '{op: a ? OP_A : (b ? OP_B : OP_C), jdo: jdo};
        second    = '{op: (a && b) ? OP_B : OP_C, jdo: jdo};
        can_issue = state == IDLE || state == DONE;
        from_slot = can_issue && full;
        direct    = can_issue && !full;
        issue_v   = from_slot || (direct && first_v);
        issue_cmd = from_slot ? head : first;
        issue_mem = issue_v && (issue_cmd.op != OP_A || issue_cmd.jdo[JDO_READ]);
        pop       = from_slot;
        push      = direct ? second_v : first_v;
        push_cmd  = direct ? second : first;
        drop      = direct ? third_v : second_v;
        ack_now   = state == REQ && mem.mem_ack;
        tout      = state == REQ && !mem.mem_ack && tcnt == 8'd0;
        base_addr = (state == DONE && cur.op != OP_A) ? addr + 1'b1 : addr;
    end

    kernel_nios2_gen2_cpu_debug_mem_bridge_cmdq u_cmdq (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = (state == REQ) ? ((ack_now || tout) ? DONE : REQ) : (issue_mem ? REQ : IDLE);
    end

    always_comb begin
        mem.mem_req   = state == REQ;
        mem.mem_we    = cur.op == OP_B;
        mem.mem_addr  = addr;
        mem.mem_wdata = cur.jdo[JDO_DATA_LSB +: 32];
    end

    // A queued address load lands after the finishing command's increment, so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr          <= '0;
            cur           <= '0;
            tcnt          <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            addr <= (issue_v && issue_cmd.op == OP_A && issue_cmd.jdo[JDO_LOAD])
                    ? issue_cmd.jdo[JDO_ADDR_LSB +: ADDR_W] : base_addr;
            if (issue_mem) cur <= issue_cmd;
            tcnt <= issue_mem ? 8'(TIMEOUT - 1) : (state == REQ ? tcnt - 1'b1 : tcnt);
            if (ack_now) MonDReg <= (cur.op == OP_B) ? mem.mem_wdata : mem.mem_rdata;
            monitor_ready <= state_n == IDLE && !push && !(full && !pop);
            monitor_error <= (monitor_error && !(a && jdo[JDO_CLR])) || tout || drop || overflow;
        end
    end
endmodule

// File: tb/tb_kernel_nios2_gen2_cpu_debug_mem_bridge.sv
// tb_kernel_nios2_gen2_cpu_debug_mem_bridge: scoreboard bench with a command-level model and a responding memory
module tb_kernel_nios2_gen2_cpu_debug_mem_bridge;
    localparam int TIMEOUT = 15;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mond;
        bit          ack;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        sa = 1'b0, sb = 1'b0, sc = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int   checks = 0, errors = 0;
    txn_t exp_q[$];
    logic [7:0]  m_addr = '0;
    logic [31:0] m_mond = '0;
    bit          m_err = 0;
    bit          no_ack = 0;
    int          force_delay = -1;

    kernel_nios2_gen2_cpu_debug_mem_bridge_if #(.ADDR_W(8)) mem();

    kernel_nios2_gen2_cpu_debug_mem_bridge #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (sa),
        .take_action_ocimem_b    (sb),
        .take_no_action_ocimem_a (sc),
        .mem                     (mem),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_val(input logic [7:0] x);
        return {x, ~x, x ^ 8'h3C, 8'hA5};
    endfunction

    function automatic logic [37:0] mk_a(input bit rd, input bit ld, input bit clr, input logic [7:0] x);
        return (38'(rd) << 35) | (38'(ld) << 34) | (38'(clr) << 33) | (38'(x) << 17);
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        return 38'(d) << 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Command-level reference: 0=A, 1=B, 2=C; memory commands push their expected transaction.
    task automatic model(input int op, input logic [37:0] j, input bit ack);
        txn_t t;
        if (op == 0) begin
            if (j[33]) m_err = 0;
            if (j[34]) m_addr = j[24:17];
            if (!j[35]) return;
        end
        t.we    = op == 1;
        t.addr  = m_addr;
        t.wdata = j[34:3];
        if (ack) m_mond = t.we ? t.wdata : rd_val(m_addr);
        else     m_err = 1;
        t.mond = m_mond;
        t.ack  = ack;
        exp_q.push_back(t);
        if (op != 0) m_addr = m_addr + 8'd1;
    endtask

    task automatic strobe(input bit x, input bit y, input bit z, input logic [37:0] j);
        @(negedge clk);
        jdo = j; sa = x; sb = y; sc = z;
        @(negedge clk);
        sa = 0; sb = 0; sc = 0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100; i++) begin
            if (monitor_ready) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL %s: monitor_ready still 0 after 100 cycles", name);
    endtask

    // Memory responder: acks each request after a per-request delay.
    int wait_cnt, delay;
    bit busy = 0, done = 0;
    initial begin mem.mem_ack = 1'b0; mem.mem_rdata = '0; end
    always @(negedge clk) begin
        mem.mem_ack = 1'b0;
        if (!mem.mem_req) busy = 0;
        else begin
            if (!busy) begin
                busy = 1; done = 0; wait_cnt = 0;
                delay = force_delay >= 0 ? force_delay : int'($urandom_range(0, 3));
                force_delay = -1;
            end
            if (!done && !no_ack) begin
                if (wait_cnt == delay) begin
                    mem.mem_ack = 1'b1;
                    mem.mem_rdata = rd_val(mem.mem_addr);
                    done = 1;
                end else wait_cnt++;
            end
        end
    end

    // Scoreboard monitor: pops on each new request and checks its outcome when it ends.
    txn_t cur_t;
    bit   in_req = 0, have_t = 0;
    int   cyc = 0;
    always @(negedge clk) begin
        if (reset) in_req = 0;
        else if (mem.mem_req) begin
            if (!in_req) begin
                in_req = 1; cyc = 0;
                if (exp_q.size() == 0) begin
                    have_t = 0; checks++; errors++;
                    $display("FAIL unexpected_req: got request at addr %h, expected none", mem.mem_addr);
                end else begin
                    have_t = 1;
                    cur_t = exp_q.pop_front();
                    chk("mem_we", 32'(mem.mem_we), 32'(cur_t.we));
                    chk("mem_addr", 32'(mem.mem_addr), 32'(cur_t.addr));
                    if (cur_t.we) chk("mem_wdata", mem.mem_wdata, cur_t.wdata);
                end
            end
            cyc++;
        end else if (in_req) begin
            in_req = 0;
            if (have_t) begin
                chk("MonDReg", MonDReg, cur_t.mond);
                if (!cur_t.ack) chk("req_cycles", 32'(cyc), 32'(TIMEOUT));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [37:0] j;
        int op;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_ready", 32'(monitor_ready), 32'd1);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_req", 32'(mem.mem_req), 32'd0);

        // Address load, then write with a 2-cycle ack delay.
        j = mk_a(0, 1, 0, 8'h10); model(0, j, 1); strobe(1, 0, 0, j);
        chk("addr_only_ready", 32'(monitor_ready), 32'd1);
        force_delay = 2;
        j = mk_b(32'hDEADBEEF); model(1, j, 1); strobe(0, 1, 0, j);
        chk("busy_after_accept", 32'(monitor_ready), 32'd0);
        wait_ready("t1");
        chk("t1_mondreg", MonDReg, 32'hDEADBEEF);
        j = '0; model(2, j, 1); strobe(0, 0, 1, j); wait_ready("t1c");

        // Address wrap on consecutive reads.
        j = mk_a(0, 1, 0, 8'hFF); model(0, j, 1); strobe(1, 0, 0, j);
        model(2, j, 1); strobe(0, 0, 1, j); wait_ready("t2a");
        model(2, j, 1); strobe(0, 0, 1, j); wait_ready("t2b");
        chk("t2_error", 32'(monitor_error), 32'(m_err));

        // Timeout, then error clear.
        no_ack = 1;
        j = mk_b(32'h12345678); model(1, j, 0); strobe(0, 1, 0, j); wait_ready("t3");
        no_ack = 0;
        chk("t3_error_set", 32'(monitor_error), 32'd1);
        j = mk_a(0, 0, 1, 8'h00); model(0, j, 1); strobe(1, 0, 0, j);
        chk("t3_error_clr", 32'(monitor_error), 32'd0);

        // One command queued during REQ, the next dropped.
        force_delay = 6;
        j = mk_b(32'hCAFEF00D); model(1, j, 1); model(2, j, 1); m_err = 1;
        strobe(0, 1, 0, j); strobe(0, 0, 1, j); strobe(0, 0, 1, j);
        wait_ready("t4");
        chk("t4_overflow_error", 32'(monitor_error), 32'd1);
        j = mk_a(0, 0, 1, 8'h00); model(0, j, 1); strobe(1, 0, 0, j);

        // Simultaneous A-read and B: read first, write from the slot.
        j = mk_a(1, 1, 0, 8'h40) | mk_b(32'h0000_0155);
        model(0, j, 1); model(1, j, 1); strobe(1, 1, 0, j); wait_ready("t5");
        chk("t5_error", 32'(monitor_error), 32'd0);

        // Random single commands.
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            j = {6'($urandom), $urandom};
            model(op, j, 1);
            strobe(op == 0, op == 1, op == 2, j);
            wait_ready("rand");
            chk("rand_error", 32'(monitor_error), 32'(m_err));
        end

        // Reset mid-REQ with a queued command; both are lost.
        no_ack = 1;
        j = mk_b(32'h0BADC0DE); model(1, j, 0);
        strobe(0, 1, 0, j); strobe(0, 0, 1, j);
        @(negedge clk); reset = 1;
        @(negedge clk);
        chk("rst_mid_req", 32'(mem.mem_req), 32'd0);
        chk("rst_mid_ready", 32'(monitor_ready), 32'd1);
        chk("rst_mid_mondreg", MonDReg, 32'd0);
        @(negedge clk); reset = 0; no_ack = 0;
        exp_q.delete();
        m_addr = '0; m_mond = '0; m_err = 0;
        j = '0; model(2, j, 1); strobe(0, 0, 1, j); wait_ready("t6");
        repeat (5) @(negedge clk);
        chk("t6_error", 32'(monitor_error), 32'd0);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
